// File: rtl/usb_line_monitor.sv
// -----------------------------------------------------------------------------
// usb_line_monitor
//
// Passive full-speed USB line monitor. The raw D+/D- pins are brought into
// the clk48 domain through a two-flop synchroniser and cleaned up by a glitch
// filter. The filtered bus state is then decoded to flag bus reset, idle and
// SE1 errors, and J<->K transitions are counted. The monitor never drives
// the bus.
//
// Optional feature (compile-time macro USB_LINE_MONITOR_EOP_EN):
//   when defined, adds end-of-packet detection (eop pulse + packets counter).
//   When undefined, those ports and their logic are absent.
//
// Parameters
//   FILTER_DEPTH : identical synchronised samples required before the
//                  filtered state may change (1..8)
//   RESET_CYCLES : SE0 cycles that make a bus reset
//   IDLE_CYCLES  : J cycles that make the bus idle
//   CNT_W        : width of se0_len, transitions and packets
//
// Ports
//   clk48        in   48 MHz sample clock
//   reset        in   asynchronous active-low reset
//   usb_d_p      in   raw D+ pin
//   usb_d_n      in   raw D- pin
//   clear        in   synchronous clear of counters and sticky flags
//   line_state   out  filtered state: 0=SE0, 1=J, 2=K, 3=SE1
//   bus_reset    out  one-cycle pulse when the SE0 run reaches RESET_CYCLES
//   reset_active out  high from the bus_reset pulse until SE0 ends
//   idle         out  high while J has lasted at least IDLE_CYCLES
//   se1_err      out  sticky SE1 flag
//   se0_len      out  current SE0 run length, saturating
//   transitions  out  count of filtered J<->K changes, wrapping
//   eop          out  (EOP_EN only) pulse on SE0(4..12 cycles)->J
//   packets      out  (EOP_EN only) count of EOPs, wrapping
// -----------------------------------------------------------------------------
module usb_line_monitor #(
    parameter int FILTER_DEPTH = 2,
    parameter int RESET_CYCLES = 480,
    parameter int IDLE_CYCLES  = 28,
    parameter int CNT_W        = 16
) (
    input  logic             clk48,
    input  logic             reset,
    input  logic             usb_d_p,
    input  logic             usb_d_n,
    input  logic             clear,
    output logic [1:0]       line_state,
    output logic             bus_reset,
    output logic             reset_active,
    output logic             idle,
    output logic             se1_err,
    output logic [CNT_W-1:0] se0_len,
    output logic [CNT_W-1:0] transitions
`ifdef USB_LINE_MONITOR_EOP_EN
    ,
    output logic             eop,
    output logic [CNT_W-1:0] packets
`endif
);

    typedef enum logic [1:0] {
        LS_SE0 = 2'd0,
        LS_J   = 2'd1,
        LS_K   = 2'd2,
        LS_SE1 = 2'd3
    } line_e;

    // Run counter only needs to reach FILTER_DEPTH (max 8).
    localparam int               RUN_W     = 4;
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(FILTER_DEPTH);
    localparam int               J_W       = $clog2(IDLE_CYCLES + 1);
    localparam logic [J_W-1:0]   J_MAX     = J_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] RESET_VAL = CNT_W'(RESET_CYCLES);

    // Synchroniser and glitch filter
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    line_e            s_code;
    line_e            cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    line_e            line_state_q, line_state_d;

    // Line decode
    logic [CNT_W-1:0] se0_raw;
    logic [CNT_W-1:0] se0_len_q, se0_len_d;
    logic             bus_reset_q, bus_reset_d;
    logic             fired_q, fired_d;
    logic             reset_active_q, reset_active_d;
    logic [J_W-1:0]   j_cnt_q, j_cnt_d;
    logic             idle_q, idle_d;
    logic             se1_err_q, se1_err_d;
    logic [CNT_W-1:0] transitions_q, transitions_d;
    logic             jk_swap;

    always_comb begin
        sync1_d = {usb_d_p, usb_d_n};
        sync2_d = sync1_q;

        // Sample {D+,D-} is reordered so that D+ high decodes to J (1) and
        // D- high decodes to K (2).
        s_code = line_e'({sync2_q[0], sync2_q[1]});
        cand_d = s_code;

        // Count how many consecutive samples have been identical; saturate
        // at FILTER_DEPTH since only "long enough" matters.
        if (s_code == cand_q) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        end else begin
            run_d = RUN_W'(1);
        end

        line_state_d = (run_d == RUN_MAX) ? s_code : line_state_q;

        // SE0 run length before clear is applied; the bus_reset threshold
        // is judged on this so that a coinciding clear cannot swallow it.
        if (line_state_d == LS_SE0) begin
            se0_raw = (se0_len_q == CNT_MAX) ? se0_len_q : se0_len_q + CNT_W'(1);
        end else begin
            se0_raw = '0;
        end
        se0_len_d = clear ? '0 : se0_raw;

        // fired_q remembers that this SE0 run already pulsed, so a clear
        // mid-run cannot produce a second pulse when se0_len climbs again.
        bus_reset_d = (line_state_d == LS_SE0) && (se0_raw == RESET_VAL) && !fired_q;
        fired_d     = (line_state_d == LS_SE0) && (fired_q || bus_reset_d);

        if (clear || (line_state_d != LS_SE0)) begin
            reset_active_d = 1'b0;
        end else if (bus_reset_d) begin
            reset_active_d = 1'b1;
        end else begin
            reset_active_d = reset_active_q;
        end

        if (clear || (line_state_d != LS_J)) begin
            j_cnt_d = '0;
        end else begin
            j_cnt_d = (j_cnt_q == J_MAX) ? j_cnt_q : j_cnt_q + J_W'(1);
        end
        idle_d = (j_cnt_d == J_MAX) && (line_state_d == LS_J);

        jk_swap = ((line_state_q == LS_J) && (line_state_d == LS_K)) ||
                  ((line_state_q == LS_K) && (line_state_d == LS_J));
        transitions_d = clear ? '0 : transitions_q + {{(CNT_W-1){1'b0}}, jk_swap};

        se1_err_d = !clear && (se1_err_q || (line_state_d == LS_SE1));
    end

    always_ff @(posedge clk48 or negedge reset) begin
        if (!reset) begin
            sync1_q        <= 2'b00;
            sync2_q        <= 2'b00;
            cand_q         <= LS_SE0;
            run_q          <= '0;
            line_state_q   <= LS_SE0;
            se0_len_q      <= '0;
            bus_reset_q    <= 1'b0;
            fired_q        <= 1'b0;
            reset_active_q <= 1'b0;
            j_cnt_q        <= '0;
            idle_q         <= 1'b0;
            se1_err_q      <= 1'b0;
            transitions_q  <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cand_q         <= cand_d;
            run_q          <= run_d;
            line_state_q   <= line_state_d;
            se0_len_q      <= se0_len_d;
            bus_reset_q    <= bus_reset_d;
            fired_q        <= fired_d;
            reset_active_q <= reset_active_d;
            j_cnt_q        <= j_cnt_d;
            idle_q         <= idle_d;
            se1_err_q      <= se1_err_d;
            transitions_q  <= transitions_d;
        end
    end

    assign line_state   = line_state_q;
    assign bus_reset    = bus_reset_q;
    assign reset_active = reset_active_q;
    assign idle         = idle_q;
    assign se1_err      = se1_err_q;
    assign se0_len      = se0_len_q;
    assign transitions  = transitions_q;

`ifdef USB_LINE_MONITOR_EOP_EN
    // EOP = SE0 lasting 4..12 cycles followed directly by J. The SE0 length
    // is tracked separately from se0_len so that clear cannot distort it.
    localparam logic [3:0] EOP_SAT = 4'd13;
    localparam logic [3:0] EOP_MIN = 4'd4;
    localparam logic [3:0] EOP_MAX = 4'd12;

    logic [3:0]       eop_len_q, eop_len_d;
    logic             eop_q, eop_d;
    logic [CNT_W-1:0] packets_q, packets_d;

    always_comb begin
        if (line_state_d == LS_SE0) begin
            eop_len_d = (eop_len_q == EOP_SAT) ? eop_len_q : eop_len_q + 4'd1;
        end else begin
            eop_len_d = 4'd0;
        end
        eop_d = (line_state_q == LS_SE0) && (line_state_d == LS_J) &&
                (eop_len_q >= EOP_MIN) && (eop_len_q <= EOP_MAX);
        packets_d = clear ? '0 : packets_q + {{(CNT_W-1){1'b0}}, eop_d};
    end

    always_ff @(posedge clk48 or negedge reset) begin
        if (!reset) begin
            eop_len_q <= 4'd0;
            eop_q     <= 1'b0;
            packets_q <= '0;
        end else begin
            eop_len_q <= eop_len_d;
            eop_q     <= eop_d;
            packets_q <= packets_d;
        end
    end

    assign eop     = eop_q;
    assign packets = packets_q;
`endif

endmodule

// File: tb/tb_usb_line_monitor.sv
// -----------------------------------------------------------------------------
// tb_usb_line_monitor
//
// Self-checking bench for usb_line_monitor with default parameters.
// Directed table of pin segments with hand-derived expectations, hand
// sequences for reset/clear/EOP corner cases, then randomized segments
// checked every cycle against a reference model that works from pin and
// line-state histories.
// -----------------------------------------------------------------------------
module tb_usb_line_monitor;

    localparam int FD = 2;
    localparam int RC = 480;
    localparam int IC = 28;
    localparam int W  = 16;
    localparam int CMAX = (1 << W) - 1;

    // pin patterns {d_p, d_n}
    localparam logic [1:0] P_SE0 = 2'b00;
    localparam logic [1:0] P_J   = 2'b10;
    localparam logic [1:0] P_K   = 2'b01;
    localparam logic [1:0] P_SE1 = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk48 = 1'b0;
    logic reset;
    logic usb_d_p, usb_d_n, clear;
    logic [1:0]   line_state;
    logic         bus_reset, reset_active, idle, se1_err;
    logic [W-1:0] se0_len, transitions;
`ifdef USB_LINE_MONITOR_EOP_EN
    logic         eop;
    logic [W-1:0] packets;
`endif

    always #10 clk48 = ~clk48;

    usb_line_monitor dut (
        .clk48        (clk48),
        .reset        (reset),
        .usb_d_p      (usb_d_p),
        .usb_d_n      (usb_d_n),
        .clear        (clear),
        .line_state   (line_state),
        .bus_reset    (bus_reset),
        .reset_active (reset_active),
        .idle         (idle),
        .se1_err      (se1_err),
        .se0_len      (se0_len),
        .transitions  (transitions)
`ifdef USB_LINE_MONITOR_EOP_EN
        ,
        .eop          (eop),
        .packets      (packets)
`endif
    );

    int errors = 0;
    int checks = 0;
    int br_count = 0;
    int eop_count = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: drive inputs, let one posedge pass, return at the
    // following negedge where outputs are stable.
    task automatic step(input logic [1:0] pins, input logic clr);
        usb_d_p = pins[1];
        usb_d_n = pins[0];
        clear   = clr;
        @(posedge clk48);
        @(negedge clk48);
        if (bus_reset === 1'b1) br_count++;
`ifdef USB_LINE_MONITOR_EOP_EN
        if (eop === 1'b1) eop_count++;
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ls"},  line_state,   0);
        check({tag, "_br"},  bus_reset,    0);
        check({tag, "_ra"},  reset_active, 0);
        check({tag, "_idl"}, idle,         0);
        check({tag, "_se1"}, se1_err,      0);
        check({tag, "_se0"}, se0_len,      0);
        check({tag, "_tr"},  transitions,  0);
`ifdef USB_LINE_MONITOR_EOP_EN
        check({tag, "_eop"}, eop,          0);
        check({tag, "_pk"},  packets,      0);
`endif
    endtask

    task automatic do_reset(input string tag);
        reset   = 1'b0;
        usb_d_p = 1'b0;
        usb_d_n = 1'b0;
        clear   = 1'b0;
        @(negedge clk48);
        @(negedge clk48);
        check_reset_vals(tag);
        reset     = 1'b1;
        br_count  = 0;
        eop_count = 0;
        model_reset();
    endtask

    // ---------------- reference model ----------------
    // Histories indexed by cycle k (state after the k-th edge since reset
    // release; k=0 is the reset state).
    logic [1:0] mp[$];
    logic       mclr[$];
    logic [1:0] mls[$];
    int         mse0[$];
    logic       mbr[$];
    logic       mra[$];
    logic       midl[$];
    logic       mse1[$];
    int         mtr[$];
    logic       meop[$];
    int         mpk[$];

    function automatic void model_reset();
        mp.delete(); mclr.delete(); mls.delete(); mse0.delete(); mbr.delete();
        mra.delete(); midl.delete(); mse1.delete(); mtr.delete(); meop.delete(); mpk.delete();
        mp.push_back(2'b00); mclr.push_back(1'b0); mls.push_back(2'd0);
        mse0.push_back(0); mbr.push_back(1'b0); mra.push_back(1'b0);
        midl.push_back(1'b0); mse1.push_back(1'b0); mtr.push_back(0);
        meop.push_back(1'b0); mpk.push_back(0);
    endfunction

    // Pins before release read as 0 (the synchroniser resets to 0).
    function automatic logic [1:0] pin_at(int i);
        if (i <= 0) return 2'b00;
        return mp[i];
    endfunction

    // {d_p,d_n}=10 is J (1), 01 is K (2)
    function automatic logic [1:0] code_of(logic [1:0] pins);
        logic [1:0] c;
        c = {pins[0], pins[1]};
        return c;
    endfunction

    // Length of the run of line state 'code' ending at cycle 'from',
    // optionally cut by a clear (a clear cycle itself reads as zero).
    function automatic int run_len(logic [1:0] code, int from, bit use_clr);
        int n = 0;
        int j = from;
        while (j >= 1 && mls[j] == code && !(use_clr && mclr[j])) begin
            n++;
            j--;
        end
        return n;
    endfunction

    function automatic void model_step(logic [1:0] pins, logic clr);
        int k;
        bit all_eq;
        bit fired;
        logic [1:0] ls;
        int n;
        int j;
        logic br;
        logic ev;
        k = mp.size();
        mp.push_back(pins);
        mclr.push_back(clr);
        // filtered state: sample seen at edge j is the pin value of edge j-2;
        // it is accepted once the last FD samples agree.
        all_eq = 1'b1;
        for (int i = k - FD - 1; i <= k - 2; i++)
            if (pin_at(i) != pin_at(k - 2)) all_eq = 1'b0;
        ls = all_eq ? code_of(pin_at(k - 2)) : mls[k - 1];
        mls.push_back(ls);
        n = run_len(2'd0, k, 1'b1);
        mse0.push_back((n > CMAX) ? CMAX : n);
        // first time this SE0 run's count reaches RC (clear ignored)
        fired = 1'b0;
        j = k - 1;
        while (j >= 1 && mls[j] == 2'd0) begin
            if (mbr[j]) fired = 1'b1;
            j--;
        end
        br = (ls == 2'd0) && (mse0[k - 1] + 1 == RC) && !fired;
        mbr.push_back(br);
        mra.push_back(!clr && ls == 2'd0 && (br || mra[k - 1]));
        midl.push_back(ls == 2'd1 && run_len(2'd1, k, 1'b1) >= IC);
        mse1.push_back(!clr && (ls == 2'd3 || mse1[k - 1]));
        if (clr) mtr.push_back(0);
        else mtr.push_back((mtr[k - 1] + (((mls[k - 1] == 2'd1 && ls == 2'd2) ||
                                           (mls[k - 1] == 2'd2 && ls == 2'd1)) ? 1 : 0)) % (CMAX + 1));
        n  = run_len(2'd0, k - 1, 1'b0);
        ev = (ls == 2'd1) && (mls[k - 1] == 2'd0) && (n >= 4) && (n <= 12);
        meop.push_back(ev);
        mpk.push_back(clr ? 0 : (mpk[k - 1] + (ev ? 1 : 0)) % (CMAX + 1));
    endfunction

    task automatic cmp_model(int k);
        check($sformatf("rnd_ls@%0d", k),  line_state,   mls[k]);
        check($sformatf("rnd_br@%0d", k),  bus_reset,    mbr[k]);
        check($sformatf("rnd_ra@%0d", k),  reset_active, mra[k]);
        check($sformatf("rnd_idl@%0d", k), idle,         midl[k]);
        check($sformatf("rnd_se1@%0d", k), se1_err,      mse1[k]);
        check($sformatf("rnd_se0@%0d", k), se0_len,      mse0[k]);
        check($sformatf("rnd_tr@%0d", k),  transitions,  mtr[k]);
`ifdef USB_LINE_MONITOR_EOP_EN
        check($sformatf("rnd_eop@%0d", k), eop,          meop[k]);
        check($sformatf("rnd_pk@%0d", k),  packets,      mpk[k]);
`endif
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0] pins;
        logic       clr;
        int         cycles;
        logic [1:0] ls;
        logic       br;
        logic       ra;
        logic       idl;
        logic       se1;
        int         se0;
        int         tr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [1:0] pins, logic clr, int cycles, logic [1:0] ls,
                                logic br, logic ra, logic idl, logic se1, int se0, int tr);
        vec_t v;
        v.pins = pins; v.clr = clr; v.cycles = cycles; v.ls = ls; v.br = br;
        v.ra = ra; v.idl = idl; v.se1 = se1; v.se0 = se0; v.tr = tr;
        vecs.push_back(v);
    endfunction

    initial begin
        reset   = 1'b0;
        usb_d_p = 1'b0;
        usb_d_n = 1'b0;
        clear   = 1'b0;

        //   pins  clr cyc  ls br ra idl se1 se0 tr
        add(P_J,   0, 3,   0, 0, 0, 0, 0, 3,   0);  // filter latency: still SE0
        add(P_J,   0, 1,   1, 0, 0, 0, 0, 0,   0);  // J on 4th cycle
        add(P_J,   0, 26,  1, 0, 0, 0, 0, 0,   0);  // 27 J cycles: not idle
        add(P_J,   0, 1,   1, 0, 0, 1, 0, 0,   0);  // 28th J cycle: idle
        add(P_J,   0, 10,  1, 0, 0, 1, 0, 0,   0);
        add(P_K,   0, 1,   1, 0, 0, 1, 0, 0,   0);  // 1-cycle K glitch
        add(P_J,   0, 6,   1, 0, 0, 1, 0, 0,   0);  // glitch filtered out
        add(P_SE0, 0, 482, 0, 0, 0, 0, 0, 479, 0);
        add(P_SE0, 0, 1,   0, 1, 1, 0, 0, 480, 0);  // bus reset threshold
        add(P_SE0, 0, 1,   0, 0, 1, 0, 0, 481, 0);
        add(P_SE0, 0, 116, 0, 0, 1, 0, 0, 597, 0);
        add(P_J,   0, 3,   0, 0, 1, 0, 0, 600, 0);
        add(P_J,   0, 1,   1, 0, 0, 0, 0, 0,   0);  // J returns: reset_active drops
        for (int i = 1; i <= 9; i++)
            add((i % 2) ? P_K : P_J, 0, 4, (i % 2) ? 2'd2 : 2'd1, 0, 0, 0, 0, 0, i);
        add(P_SE1, 0, 5,   3, 0, 0, 0, 1, 0,   9);
        add(P_J,   0, 6,   1, 0, 0, 0, 1, 0,   9);  // sticky after J
        add(P_J,   1, 1,   1, 0, 0, 0, 0, 0,   0);  // clear
        add(P_J,   0, 1,   1, 0, 0, 0, 0, 0,   0);

        do_reset("rst0");
        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].pins, vecs[i].clr);
            check($sformatf("v%0d_ls", i),  line_state,   vecs[i].ls);
            check($sformatf("v%0d_br", i),  bus_reset,    vecs[i].br);
            check($sformatf("v%0d_ra", i),  reset_active, vecs[i].ra);
            check($sformatf("v%0d_idl", i), idle,         vecs[i].idl);
            check($sformatf("v%0d_se1", i), se1_err,      vecs[i].se1);
            check($sformatf("v%0d_se0", i), se0_len,      vecs[i].se0);
            check($sformatf("v%0d_tr", i),  transitions,  vecs[i].tr);
        end
        check("table_br_once", br_count, 1);

        // ---- reset mid-run, then clear coinciding with the threshold ----
        do_reset("rst1");
        for (int c = 0; c < 200; c++) step(P_SE0, 1'b0);
        check("mid_se0_pre", se0_len, 200);
        #3;
        reset = 1'b0;
        #1;
        check("mid_async_se0", se0_len, 0);
        check("mid_async_ls", line_state, 0);
        @(negedge clk48);
        reset    = 1'b1;
        br_count = 0;
        for (int c = 0; c < 300; c++) step(P_SE0, 1'b0);
        check("post_rel_se0", se0_len, 300);
        check("post_rel_nobr", br_count, 0);
        for (int c = 0; c < 179; c++) step(P_SE0, 1'b0);
        check("thr_pre_se0", se0_len, 479);
        step(P_SE0, 1'b1);
        check("thr_clr_br", bus_reset, 1);
        check("thr_clr_ra", reset_active, 0);
        check("thr_clr_se0", se0_len, 0);
        for (int c = 0; c < 490; c++) step(P_SE0, 1'b0);
        check("thr_once_se0", se0_len, 490);
        check("thr_once_br", br_count, 1);
        check("thr_once_ra", reset_active, 0);

`ifdef USB_LINE_MONITOR_EOP_EN
        // ---- EOP ----
        do_reset("rst2");
        for (int c = 0; c < 10; c++) step(P_K, 1'b0);
        for (int c = 0; c < 8; c++)  step(P_SE0, 1'b0);
        for (int c = 0; c < 8; c++)  step(P_J, 1'b0);
        check("eop8_cnt", eop_count, 1);
        check("eop8_pk", packets, 1);
        for (int c = 0; c < 8; c++)  step(P_K, 1'b0);
        for (int c = 0; c < 2; c++)  step(P_SE0, 1'b0);
        for (int c = 0; c < 8; c++)  step(P_J, 1'b0);
        check("eop2_cnt", eop_count, 1);
        check("eop2_pk", packets, 1);
        for (int c = 0; c < 8; c++)  step(P_K, 1'b0);
        for (int c = 0; c < 13; c++) step(P_SE0, 1'b0);
        for (int c = 0; c < 8; c++)  step(P_J, 1'b0);
        check("eop13_cnt", eop_count, 1);
        step(P_J, 1'b1);
        check("eop_clr_pk", packets, 0);
`endif

        // ---- randomized segments against the model ----
        do_reset("rst3");
        begin
            int total;
            total = 0;
            while (total < 6000) begin
                logic [1:0] pins;
                int r;
                int d;
                int len;
                r = $urandom_range(0, 99);
                if (r < 35)      pins = P_J;
                else if (r < 65) pins = P_K;
                else if (r < 90) pins = P_SE0;
                else             pins = P_SE1;
                d = $urandom_range(0, 9);
                if (d <= 2)      len = $urandom_range(1, 3);
                else if (d <= 6) len = $urandom_range(4, 14);
                else if (d <= 8 || pins != P_SE0) len = $urandom_range(20, 40);
                else             len = $urandom_range(470, 500);
                for (int c = 0; c < len; c++) begin
                    logic clr;
                    clr = ($urandom_range(0, 63) == 0);
                    step(pins, clr);
                    model_step(pins, clr);
                    cmp_model(mp.size() - 1);
                end
                total += len;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
